// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers, valid/ready on both sides.
// Define SOBEL_MAG_EN to build the saturated |gx|+|gy| magnitude output.
module sobel_stream #(
  parameter int unsigned IMG_W  = 482,
  parameter int unsigned IMG_H  = 482,
  parameter int unsigned DW     = 8,
  parameter int unsigned THRESH = 100
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_sof,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_x,
  output logic [DW-1:0] out_y,
  output logic [DW-1:0] out_mag,
  output logic          out_last,
  output logic          frame_done
);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam int unsigned GW = DW + 3;

  typedef enum logic [1:0] {StIdle, StFill, StRun} state_e;

  state_e             state_q;
  logic [RW-1:0]      row_q;
  logic [CW-1:0]      col_q;
  logic [DW-1:0]      lb0_q [IMG_W];  // row r-2
  logic [DW-1:0]      lb1_q [IMG_W];  // row r-1
  logic [2:0][DW-1:0] win0_q, win1_q, win_new;  // [0]=top, [1]=mid, [2]=bottom
  logic               out_valid_q, out_last_q, frame_done_q;
  logic [DW-1:0]      out_x_q, out_y_q;

  logic               accept, restart, last_col, last_row, last_pix, emit;
  logic [RW-1:0]      cur_row;
  logic [CW-1:0]      cur_col;
  logic signed [GW-1:0] gx, gy;
  logic [GW-1:0]      abs_gx, abs_gy;
  logic               edge_x, edge_y;

  function automatic logic [GW-1:0] wsum(logic [DW-1:0] a, logic [DW-1:0] b, logic [DW-1:0] c);
    return {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c};
  endfunction

  assign in_ready = !out_valid_q || out_ready;

  always_comb begin
    accept   = in_valid && in_ready;
    // An sof pixel, or any pixel while idle, is pixel (0,0) of a new frame.
    restart  = in_sof || (state_q == StIdle);
    cur_row  = restart ? '0 : row_q;
    cur_col  = restart ? '0 : col_q;
    last_col = (cur_col == CW'(IMG_W - 1));
    last_row = (cur_row == RW'(IMG_H - 1));
    last_pix = last_row && last_col;
    emit     = accept && !restart && (state_q == StRun) && (cur_col >= CW'(2));
    win_new  = {in_data, lb1_q[cur_col], lb0_q[cur_col]};
    gx       = signed'(wsum(win_new[0], win_new[1], win_new[2])
                       - wsum(win0_q[0], win0_q[1], win0_q[2]));
    gy       = signed'(wsum(win0_q[0], win1_q[0], win_new[0])
                       - wsum(win0_q[2], win1_q[2], win_new[2]));
    abs_gx   = gx[GW-1] ? -gx : gx;
    abs_gy   = gy[GW-1] ? -gy : gy;
    edge_x   = {{(32 - GW){1'b0}}, abs_gx} > THRESH;
    edge_y   = {{(32 - GW){1'b0}}, abs_gy} > THRESH;
  end

`ifdef SOBEL_MAG_EN
  logic [GW-1:0] mag_sum;
  logic [DW-1:0] mag, out_mag_q;
  always_comb begin
    mag_sum = abs_gx + abs_gy;
    mag     = (mag_sum > GW'((2 ** DW) - 1)) ? '1 : mag_sum[DW-1:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_mag_q <= '0;
    end else if (emit) begin
      out_mag_q <= mag;
    end
  end
  assign out_mag = out_mag_q;
`else
  assign out_mag = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      row_q        <= '0;
      col_q        <= '0;
      win0_q       <= '0;
      win1_q       <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        lb0_q[i] <= '0;
        lb1_q[i] <= '0;
      end
      out_valid_q  <= 1'b0;
      out_x_q      <= '0;
      out_y_q      <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      frame_done_q <= 1'b0;
      if (out_valid_q && out_ready) out_valid_q <= 1'b0;
      if (accept) begin
        lb0_q[cur_col] <= lb1_q[cur_col];
        lb1_q[cur_col] <= in_data;
        win0_q         <= win1_q;
        win1_q         <= win_new;
        if (last_pix) begin
          state_q      <= StIdle;
          row_q        <= '0;
          col_q        <= '0;
          frame_done_q <= 1'b1;
        end else begin
          if (last_col) begin
            col_q <= '0;
            row_q <= cur_row + 1'b1;
          end else begin
            col_q <= cur_col + 1'b1;
            row_q <= cur_row;
          end
          if ((cur_row == RW'(1)) && last_col) state_q <= StRun;
          else if (restart)                    state_q <= StFill;
        end
        // A new sample overwrites the register even when the old one leaves this edge.
        if (emit) begin
          out_valid_q <= 1'b1;
          out_x_q     <= {DW{edge_x}};
          out_y_q     <= {DW{edge_y}};
          out_last_q  <= last_pix;
        end
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_x      = out_x_q;
  assign out_y      = out_y_q;
  assign out_last   = out_last_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_sobel_stream.sv
// Bench for sobel_stream: directed scenarios plus random frames against a frame-level model.
module tb_sobel_stream;
  localparam int W = 5, H = 4, DW = 8, TH = 100;

  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, in_sof = 1'b0, out_ready = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic in_ready, out_valid, out_last, frame_done;
  logic [DW-1:0] out_x, out_y, out_mag;

  int checks = 0, errors = 0;
  int rdy_mode = 0;
  int img [H][W];
  int mr = 0, mc = 0, fd_count = 0;
  bit midle = 1'b1, exp_fd = 1'b0, prev_v = 1'b0;
  logic [3*DW:0] expq[$], seen[$], prev_w;

  sobel_stream #(.IMG_W(W), .IMG_H(H), .DW(DW), .THRESH(TH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_x(out_x),
    .out_y(out_y), .out_mag(out_mag), .out_last(out_last), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Direct 3x3 convolution over the stored frame image.
  function automatic logic [3*DW:0] model_out(int r, int c, bit last);
    int gx, gy, ax, ay;
    logic [DW-1:0] x, y, mg;
    gx = (img[r-2][c] + 2*img[r-1][c] + img[r][c])
       - (img[r-2][c-2] + 2*img[r-1][c-2] + img[r][c-2]);
    gy = (img[r-2][c-2] + 2*img[r-2][c-1] + img[r-2][c])
       - (img[r][c-2] + 2*img[r][c-1] + img[r][c]);
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    x  = (ax > TH) ? 8'hff : 8'h00;
    y  = (ay > TH) ? 8'hff : 8'h00;
`ifdef SOBEL_MAG_EN
    mg = (ax + ay > 255) ? 8'hff : 8'(ax + ay);
`else
    mg = 8'h00;
`endif
    return {last, mg, y, x};
  endfunction

  task automatic model_accept(input int d, input bit sof);
    bit last;
    if (sof || midle) begin mr = 0; mc = 0; midle = 1'b0; end
    img[mr][mc] = d;
    last = (mr == H-1) && (mc == W-1);
    if (mr >= 2 && mc >= 2) expq.push_back(model_out(mr, mc, last));
    if (last) begin
      exp_fd = 1'b1; midle = 1'b1; mr = 0; mc = 0;
    end else if (mc == W-1) begin
      mc = 0; mr++;
    end else begin
      mc++;
    end
  endtask

  // Per-cycle compare process.
  initial begin
    logic [3*DW:0] dut_w, w;
    forever begin
      @(negedge clk);
      if (rst) begin prev_v = 1'b0; continue; end
      dut_w = {out_last, out_mag, out_y, out_x};
      check("frame_done", frame_done, exp_fd);
      exp_fd = 1'b0;
      if (frame_done) fd_count++;
      check("in_ready", in_ready, !out_valid || out_ready);
      if (prev_v) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", dut_w, prev_w);
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got %h expected no output", dut_w);
        end else begin
          w = expq.pop_front();
          check("out", dut_w, w);
        end
        seen.push_back(dut_w);
      end
      prev_v = out_valid && !out_ready;
      prev_w = dut_w;
      if (in_valid && in_ready) model_accept(in_data, in_sof);
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode != 0) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input int d, input bit sof);
    int n = 0;
    in_valid = 1'b1; in_data = DW'(d); in_sof = sof;
    @(negedge clk);
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: in_ready got 0 expected 1");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_sof = 1'b0;
  endtask

  function automatic int pat(int kind, int r, int c);
    case (kind)
      0: return 50;
      1: return (c < 2) ? 0 : 200;
      2: return (c < 2) ? 200 : 0;
      3: return (r < 2) ? 0 : 200;
      default: return ($urandom_range(0, 1) != 0) ? (($urandom_range(0, 1) != 0) ? 255 : 0)
                                                  : int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic send_range(input int kind, input int first, input int npix, input bit sof,
                            input bit gaps);
    for (int i = first; i < first + npix; i++) begin
      send(pat(kind, i / W, i % W), sof && (i == 0));
      if (gaps) idle($urandom_range(0, 2));
    end
  endtask

  task automatic drain();
    int n = 0;
    rdy_mode = 0; out_ready = 1'b1;
    while ((expq.size() != 0 || out_valid) && n < 300) begin @(negedge clk); n++; end
    if (n >= 300) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending expected 0", expq.size());
    end
    idle(2);
  endtask

  // Hand-derived results for the directed 5x4 frames.
  task automatic check_pattern(input string nm, input int kind);
    logic [DW-1:0] x, y, mg;
    check({nm, "_count"}, seen.size(), 6);
    check({nm, "_frame_done"}, fd_count, 1);
    for (int i = 0; i < seen.size() && i < 6; i++) begin
      x = ((kind == 1 || kind == 2) && (i % 3 != 2)) ? 8'hff : 8'h00;
      y = (kind == 3) ? 8'hff : 8'h00;
`ifdef SOBEL_MAG_EN
      mg = x | y;
`else
      mg = 8'h00;
`endif
      check(nm, seen[i], {(i == 5), mg, y, x});
    end
  endtask

  task automatic start_scn();
    seen.delete(); fd_count = 0;
  endtask

  initial begin
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_x", out_x, 0);
    check("rst_out_y", out_y, 0);
    check("rst_out_mag", out_mag, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_done", frame_done, 0);
    #9 rst = 1'b0;
    idle(1);

    for (int k = 0; k < 4; k++) begin
      start_scn();
      send_range(k, 0, W*H, 1'b1, 1'b0);
      drain();
      check_pattern((k == 0) ? "flat" : (k == 1) ? "vert" : (k == 2) ? "mirror" : "horiz", k);
    end

    // Backpressure right after the first output.
    start_scn();
    fork
      send_range(1, 0, W*H, 1'b1, 1'b0);
      begin
        int n = 0;
        while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          check("bp_in_ready", in_ready, 0);
          check("bp_out_x", out_x, 8'hff);
          check("bp_out_y", out_y, 8'h00);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    check_pattern("bp", 1);

    // Asynchronous reset in the middle of row 2.
    start_scn();
    send_range(1, 0, 2*W + 3, 1'b1, 1'b0);
    out_ready = 1'b0;
    #2;
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    expq.delete(); midle = 1'b1; exp_fd = 1'b0; mr = 0; mc = 0;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_x", out_x, 0);
    check("arst_out_last", out_last, 0);
    check("arst_in_ready", in_ready, 1);
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b0; out_ready = 1'b1;
    start_scn();
    send_range(1, 0, W*H, 1'b0, 1'b0);
    drain();
    check_pattern("after_rst", 1);

    // in_sof restart in row 1.
    start_scn();
    send_range(4, 0, W + 2, 1'b1, 1'b0);
    send_range(1, 0, 2*W + 2, 1'b1, 1'b0);
    idle(2);
    check("sof_no_early_out", seen.size(), 0);
    send_range(1, 2*W + 2, 1, 1'b0, 1'b0);
    idle(2);
    check("sof_first_out", seen.size(), 1);
    send_range(1, 2*W + 3, W*H - 2*W - 3, 1'b0, 1'b0);
    drain();
    check_pattern("sof", 1);

    // Random frames, random gaps and backpressure, occasional aborts.
    rdy_mode = 1;
    for (int f = 0; f < 12; f++) begin
      int npix = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, W*H - 1)) : W*H;
      send_range(4, 0, npix, 1'b1, 1'b1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sobel_stream.md
Name: sobel_stream

Overview:
- Parametrised streaming 3x3 Sobel edge detector.
- Successor of the fixed 482-wide sobel block.
- Accepts one raster-order pixel per handshake, keeps two line buffers of IMG_W pixels, and emits thresholded X/Y edge maps for interior pixels only.
- Sits between the pixel source and the frame writer, with valid/ready backpressure on both sides.

Parameters:
IMG_W, 482, pixels per line (>=3)
IMG_H, 482, lines per frame (>=3)
DW, 8, pixel width in bits
THRESH, 100, edge threshold; strict compare against the absolute gradient

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
in_valid  in  1  input pixel valid
in_ready  out  1  block can accept a pixel
in_sof  in  1  marks the current input pixel as pixel (0,0) of a new frame
in_data  in  DW  input pixel, unsigned
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts the output sample
out_x  out  DW  all-ones if |gx|>THRESH, else 0
out_y  out  DW  all-ones if |gy|>THRESH, else 0
out_mag  out  DW  saturated magnitude (see Optional Feature)
out_last  out  1  high with the last interior output of a frame
frame_done  out  1  one-cycle pulse after the last input pixel of a frame is accepted

Behaviour:
- Reset: clock and reset are fixed as one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: out_valid=0, out_x=out_y=out_mag=0, out_last=0, frame_done=0, state=IDLE, row=col=0, line buffers 0.
- Accept rule: a pixel is accepted on a clk edge with in_valid&&in_ready.
- Ready rule: in_ready = !out_valid || out_ready (single output register; no combinational path from in_valid to in_ready).
- Position counters: col counts 0..IMG_W-1 and wraps to 0 with row+1. Row counts 0..IMG_H-1.
- Window: p[r][c], r,c in 0..2; p[0][0] is the oldest pixel (top-left); p[2][2] is the pixel being accepted.
- gx = (p02+2p12+p22)-(p00+2p10+p20).
- gy = (p00+2p01+p02)-(p20+2p21+p22).
- Arithmetic: gx and gy are signed, DW+3 bits wide, and never overflow. Thresholding uses the absolute value; negative edges detect.
- Output trigger: an output is produced when the accepted pixel has row>=2 and col>=2. It describes centre (row-1, col-1). Registered, so out_valid is high in the cycle after the accepting edge.
- Output hold: out_valid and out_* stay stable until out_valid&&out_ready.
- Output count: exactly (IMG_H-2)*(IMG_W-2) outputs per frame. Border pixels produce nothing. No wrap-around windows across line ends: the col>=2 gating enforces this.
- State machine:
  - IDLE: waiting for first pixel; any accepted pixel counts as (0,0) -> FILL.
  - FILL: rows 0-1; no outputs; after accepting (1,IMG_W-1) -> RUN.
  - RUN: rows 2..IMG_H-1; outputs per the rule above.
  - Accepting (IMG_H-1,IMG_W-1) -> IDLE, pulses frame_done next cycle and sets out_last on that output.
- in_sof: accepted in_sof forces that pixel to (0,0), state FILL, regardless of current state. Mid-frame abort: pending out_valid is still delivered; buffers are not cleared (stale data is never emitted because the FILL gating applies).
- Simultaneous accept and output handshake in one cycle: new output replaces old, no bubble.
- Async rst mid-frame: all state cleared immediately; the next accepted pixel is (0,0).

Optional Feature:
- SOBEL_MAG_EN defined: out_mag = min(|gx|+|gy|, 2^DW-1), registered with out_x/out_y.
- Not defined: out_mag is constant 0 and no adder/saturator is built. Other outputs are identical in both builds.

Test Plan:
All scenarios use IMG_W=5, IMG_H=4, DW=8, THRESH=100, with out_ready=1 unless stated.
- Flat frame (all 50): exactly 6 outputs, all out_x=out_y=0, out_last on the 6th, frame_done pulses once. With SOBEL_MAG_EN: out_mag=0.
- Vertical edge (cols 0-1=0, cols 2-4=200): per row, centres c1,c2 give gx=800, out_x=255; c3 gives out_x=0; out_y=0 everywhere. With SOBEL_MAG_EN: out_mag=255 at c1,c2.
- Mirrored edge (cols 0-1=200, cols 2-4=0): gx=-800 gives out_x=255 at c1,c2 (abs check). Horizontal edge rows 0-1=0, rows 2-3=200: out_y=255 at the r1,r2 centres.
- Backpressure: out_ready=0 for 5 cycles after the first output -> in_ready=0, out_x/out_y held stable. Release -> all 6 outputs in order, none lost or duplicated.
- rst asserted asynchronously mid-row 2: outputs drop to 0 without a clock edge. Next full frame yields 6 correct outputs.
- in_sof mid-frame at row 1: the frame restarts there. No output until 2 rows + 3 pixels are accepted; 6 outputs follow for the new frame.
